// File: rtl/gat_feat_readout_if.sv
// rtl/gat_feat_readout_if.sv - word stream from the feature readout toward the host DMA
// Purpose: bundles the valid/ready output stream of gat_feat_readout.
// Signals:
//   m_tdata  - stream word (DATA_W bits)
//   m_tvalid - word on m_tdata is valid
//   m_tready - sink accepts the word this cycle
//   m_tlast  - word is the final one of the readout
// Modports: master (readout side), slave (DMA side).
interface gat_feat_readout_if #(
  parameter int DATA_W = 32
) ();
  logic [DATA_W-1:0] m_tdata;
  logic              m_tvalid;
  logic              m_tready;
  logic              m_tlast;

  modport master (output m_tdata, output m_tvalid, output m_tlast, input m_tready);
  modport slave  (input m_tdata, input m_tvalid, input m_tlast, output m_tready);
endinterface

// File: rtl/gat_feat_readout.sv
// rtl/gat_feat_readout.sv - drains the GAT new-feature BRAM onto a valid/ready word stream
// Purpose: after GAT inference, reads num_words feature words from the BRAM read
//   port and streams them out with TLAST on the final word. A credit-limited
//   prefetch FIFO absorbs backpressure without ever overflowing.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   start           - one-cycle request, accepted only when idle
//   num_words       - word count, sampled at start (saturated to the BRAM depth)
//   gat_ready       - GAT core idle with results valid, sampled before streaming
//   busy, done      - transfer in progress / one-cycle completion pulse
//   feat_bram_addrb - byte address to the feature BRAM (word aligned)
//   feat_bram_dout  - BRAM read data
//   m_axis          - output word stream (master modport)
module gat_feat_readout #(
  parameter int NEW_FEATURE_WIDTH  = 32,
  parameter int NEW_FEATURE_DEPTH  = 43328,
  parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
  parameter int RD_LATENCY         = 1,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [NEW_FEATURE_ADDR_W:0]   num_words,
  input  logic                          gat_ready,
  output logic                          busy,
  output logic                          done,
  output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
  input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
  gat_feat_readout_if.master            m_axis
);
  localparam int AW  = NEW_FEATURE_ADDR_W;
  localparam int CW  = AW + 1;
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0]  CNT_ONE = CW'(1);
  localparam logic [CW-1:0]  DEPTH_C = CW'(NEW_FEATURE_DEPTH);
  localparam logic [FCW-1:0] FULL_C  = FCW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_RDY, STREAM, FINISH} state_t;

  state_t                       state_q, state_d;
  logic [CW-1:0]                count_q, count_d;
  logic [CW-1:0]                rd_idx_q, rd_idx_d;
  logic [CW-1:0]                out_idx_q, out_idx_d;
  logic [AW+1:0]                addr_q, addr_d;
  // Stage 0 marks "address just presented"; stage RD_LATENCY marks "dout valid now".
  logic [RD_LATENCY:0]          pipe_q;
  logic [NEW_FEATURE_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]                wr_ptr_q, rd_ptr_q;
  logic [FCW-1:0]               fcnt_q, fcnt_d;
  logic                         issue, can_issue, push, pop, tvalid, tlast;
  int                           in_flight;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    in_flight = 0;
    for (int i = 0; i <= RD_LATENCY; i++) begin
      in_flight = in_flight + int'(pipe_q[i]);
    end
  end

  // Every issued read already owns a FIFO slot, so the FIFO cannot overflow.
  assign can_issue = (rd_idx_q < count_q) && ((in_flight + int'(fcnt_q)) < FIFO_DEPTH);
  assign push      = pipe_q[RD_LATENCY];
  assign tvalid    = (fcnt_q != '0);
  assign tlast     = tvalid && (out_idx_q == count_q - CNT_ONE);
  assign pop       = tvalid && m_axis.m_tready;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rd_idx_d  = rd_idx_q;
    out_idx_d = out_idx_q;
    addr_d    = addr_q;
    issue     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          count_d   = (num_words > DEPTH_C) ? DEPTH_C : num_words;
          rd_idx_d  = '0;
          out_idx_d = '0;
          state_d   = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (gat_ready) begin
          if (count_q == '0) begin
            state_d = FINISH;
          end else begin
            // The first read goes out on the transition so its address is
            // already on the bus in the first STREAM cycle.
            issue   = can_issue;
            state_d = STREAM;
          end
        end
      end
      STREAM: begin
        issue = can_issue;
        if (pop && tlast) state_d = FINISH;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (issue) begin
      addr_d   = {rd_idx_q[AW-1:0], 2'b00};
      rd_idx_d = rd_idx_q + CNT_ONE;
    end
    if (pop) out_idx_d = out_idx_q + CNT_ONE;
  end

  always_comb begin
    fcnt_d = fcnt_q;
    if (push && !pop) fcnt_d = fcnt_q + FCW'(1);
    else if (!push && pop) fcnt_d = fcnt_q - FCW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      rd_idx_q  <= '0;
      out_idx_q <= '0;
      addr_q    <= '0;
      pipe_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rd_idx_q  <= rd_idx_d;
      out_idx_q <= out_idx_d;
      addr_q    <= addr_d;
      pipe_q    <= {pipe_q[RD_LATENCY-1:0], issue};
      fcnt_q    <= fcnt_d;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= feat_bram_dout;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && (fcnt_q == FULL_C)));

  // busy covers the accepting cycle so it is high from acceptance to done.
  assign busy            = ((state_q == IDLE) && start) || (state_q == WAIT_RDY) || (state_q == STREAM);
  assign done            = (state_q == FINISH);
  assign feat_bram_addrb = addr_q;
  assign m_axis.m_tvalid = tvalid;
  assign m_axis.m_tlast  = tlast;
  assign m_axis.m_tdata  = tvalid ? mem_q[rd_ptr_q] : '0;
endmodule

// File: tb/tb_gat_feat_readout.sv
// tb/tb_gat_feat_readout.sv - self-checking bench for gat_feat_readout
module tb_gat_feat_readout;
  localparam int AW     = 16;
  localparam int BUDGET = 50000;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW:0]   num_words;
  logic          gat_ready;
  logic          busy;
  logic          done;
  logic [AW+1:0] feat_bram_addrb;
  logic [31:0]   feat_bram_dout;

  int checks   = 0;
  int failures = 0;

  gat_feat_readout_if #(.DATA_W(32)) m_if ();

  gat_feat_readout dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .num_words       (num_words),
    .gat_ready       (gat_ready),
    .busy            (busy),
    .done            (done),
    .feat_bram_addrb (feat_bram_addrb),
    .feat_bram_dout  (feat_bram_dout),
    .m_axis          (m_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle-latency BRAM whose word at index i holds the value i.
  always @(posedge clk) feat_bram_dout <= 32'(feat_bram_addrb >> 2);

  typedef struct {
    logic [AW:0] nwords;
    logic [3:0]  rdy;           // m_tready pattern, bit (cycle % 4)
    int          gat_wait;      // cycles gat_ready stays low after start
    int          restart_cyc;   // cycle of a second start (-1 none)
    int          exp_beats;
    int          exp_done_cyc;  // -1 skip
    int          exp_first_valid;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input int cyc);
    start     = (cyc == 0) || (cyc == v.restart_cyc);
    num_words = (cyc == 0) ? v.nwords : 17'd3;
    gat_ready = (cyc >= v.gat_wait) && ((v.gat_wait == 0) || (cyc < v.gat_wait + 2));
    m_if.m_tready = v.rdy[2'(cyc % 4)];
  endtask

  task automatic run_vec(input vec_t v);
    int cyc, beats, done_cnt, done_cyc, last_hs, busy_cyc, first_valid, exp_next, oc;
    logic [AW+1:0] addr0, prev_addr;
    logic prev_stall;
    logic [31:0] prev_data;
    @(posedge clk); #1;
    addr0 = feat_bram_addrb;
    prev_addr = addr0;
    exp_next = (addr0 == '0) ? 4 : 0;
    cyc = 0; beats = 0; done_cnt = 0; done_cyc = -1; last_hs = -1;
    busy_cyc = 0; first_valid = -1; prev_stall = 1'b0; prev_data = '0;
    drive(v, 0);
    while (1) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc < 0) begin
        if (busy) busy_cyc++;
      end else begin
        chk("busy_after_done", busy, 0);
      end
      if (v.gat_wait > 0 && cyc < v.gat_wait) begin
        chk("gate_addr_hold", feat_bram_addrb, addr0);
        chk("gate_busy", busy, 1);
      end
      if (feat_bram_addrb != prev_addr) begin
        chk("addr_seq", feat_bram_addrb, exp_next);
        exp_next += 4;
        prev_addr = feat_bram_addrb;
      end
      if (beats > 0) begin
        oc = int'(feat_bram_addrb >> 2) + 1 - beats;
        chk("outstanding_over_4", oc > 4, 0);
      end
      if (prev_stall) begin
        chk("stall_valid", m_if.m_tvalid, 1);
        chk("stall_data", m_if.m_tdata, prev_data);
      end
      if (m_if.m_tvalid) begin
        if (first_valid < 0) first_valid = cyc;
        chk("tlast", m_if.m_tlast, beats == v.exp_beats - 1);
        if (m_if.m_tready) begin
          chk("tdata", m_if.m_tdata, beats);
          if (m_if.m_tlast) last_hs = cyc;
          beats++;
        end
      end else begin
        chk("tlast_idle", m_if.m_tlast, 0);
      end
      prev_stall = m_if.m_tvalid && !m_if.m_tready;
      prev_data  = m_if.m_tdata;
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
      if (cyc >= BUDGET) begin
        chk("timeout_done_seen", done_cyc >= 0, 1);
        break;
      end
      @(posedge clk); #1;
      cyc++;
      drive(v, cyc);
    end
    start = 1'b0;
    chk("beats", beats, v.exp_beats);
    chk("done_count", done_cnt, 1);
    chk("busy_span", busy_cyc, done_cyc);
    chk("first_valid_cyc", first_valid, v.exp_first_valid);
    if (v.exp_done_cyc >= 0) chk("done_cyc", done_cyc, v.exp_done_cyc);
    if (v.exp_beats > 0) begin
      chk("done_after_last", done_cyc, last_hs + 1);
      chk("final_addr", feat_bram_addrb, (v.exp_beats - 1) * 4);
    end else begin
      chk("zero_len_addr", feat_bram_addrb, addr0);
    end
  endtask

  initial begin
    int hs, k;
    //          nwords     rdy      gat restart beats  done   first
    vecs[0] = '{17'd16,    4'b1111, 0,  -1,     16,    20,    4};  // basic stream
    vecs[1] = '{17'd5,     4'b1111, 10, -1,     5,     18,    13}; // gating, short gat_ready
    vecs[2] = '{17'd8,     4'b1001, 0,  -1,     8,     -1,    4};  // backpressure 1,0,0,1
    vecs[3] = '{17'd16,    4'b1111, 0,  8,      16,    20,    4};  // start mid-stream ignored
    vecs[4] = '{17'd16,    4'b1111, 0,  20,     16,    20,    4};  // start in FINISH ignored
    vecs[5] = '{17'd1,     4'b1111, 0,  -1,     1,     5,     4};  // single word
    vecs[6] = '{17'd0,     4'b1111, 0,  -1,     0,     2,     -1}; // zero length
    vecs[7] = '{17'd65535, 4'b1111, 0,  -1,     43328, 43332, 4};  // saturated count
    vecs[8] = '{17'd4,     4'b1111, 0,  -1,     4,     8,     4};  // after async reset

    rst_n = 1'b0; start = 1'b0; num_words = '0; gat_ready = 1'b0; m_if.m_tready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tvalid", m_if.m_tvalid, 0);
    chk("rst_tlast", m_if.m_tlast, 0);
    chk("rst_tdata", m_if.m_tdata, 0);
    chk("rst_addr", feat_bram_addrb, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Asynchronous reset after five handshakes of a 16-word transfer.
    @(posedge clk); #1;
    start = 1'b1; num_words = 17'd16; gat_ready = 1'b1; m_if.m_tready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    hs = 0; k = 0;
    while (hs < 5 && k < 100) begin
      @(negedge clk);
      if (m_if.m_tvalid && m_if.m_tready) hs++;
      k++;
    end
    chk("reset_seq_handshakes", hs, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_done", done, 0);
    chk("async_tvalid", m_if.m_tvalid, 0);
    chk("async_tlast", m_if.m_tlast, 0);
    chk("async_tdata", m_if.m_tdata, 0);
    chk("async_addr", feat_bram_addrb, 0);
    @(negedge clk);
    chk("held_done", done, 0);
    chk("held_tvalid", m_if.m_tvalid, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    run_vec(vecs[8]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
